// File: rtl/pipe_last_to_length.sv
// Store-and-forward converter: buffers last-delimited packets and replays each with its beat count.
// Optional build macro PIPE_LAST_TO_LENGTH_STATS_EN adds packet/truncation counters.
module pipe_last_to_length #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned PKTS  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_enq_ena,
  input  logic [WIDTH-1:0] i_in_enq_v,
  input  logic             i_in_enq_last,
  output logic             o_in_enq_rdy_c,
  output logic             o_out_enq_ena_c,
  output logic [WIDTH-1:0] o_out_enq_v_c,
  output logic [15:0]      o_out_enq_size_c,
  input  logic             i_out_enq_rdy
`ifdef PIPE_LAST_TO_LENGTH_STATS_EN
  ,
  output logic [31:0]      o_pkt_count,
  output logic [15:0]      o_trunc_count
`endif
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned SW  = AW + 1;
  localparam int unsigned LW  = $clog2(PKTS);
  localparam int unsigned LPW = LW + 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  logic [WIDTH-1:0] r_data_mem [DEPTH];
  logic [PW-1:0]    r_data_wr;
  logic [PW-1:0]    r_data_rd;
  logic [SW-1:0]    r_len_mem [PKTS];
  logic [LPW-1:0]   r_len_wr;
  logic [LPW-1:0]   r_len_rd;
  logic [AW-1:0]    r_in_count;
  logic [AW-1:0]    r_out_remaining;
  state_t           r_state;

  state_t           w_state_nxt;
  logic [AW-1:0]    w_remaining_nxt;
  logic             w_len_pop;
  logic             w_data_full;
  logic             w_len_full;
  logic             w_len_empty;
  logic             w_in_acc;
  logic             w_len_push;
  logic             w_trunc;
  logic             w_xfer;
  logic [SW-1:0]    w_len_head;
  logic [WIDTH-1:0] w_data_head;

  // FIFO status from registered pointers only
  assign w_data_full = (r_data_wr[PW-1] != r_data_rd[PW-1]) &&
                       (r_data_wr[AW-1:0] == r_data_rd[AW-1:0]);
  assign w_len_full  = (r_len_wr[LPW-1] != r_len_rd[LPW-1]) &&
                       (r_len_wr[LW-1:0] == r_len_rd[LW-1:0]);
  assign w_len_empty = (r_len_wr == r_len_rd);

  assign o_in_enq_rdy_c = !w_data_full && !w_len_full;
  assign w_in_acc       = i_in_enq_ena && o_in_enq_rdy_c;
  assign w_trunc        = (r_in_count == AW'(DEPTH - 1));
  assign w_len_push     = w_in_acc && (i_in_enq_last || w_trunc);

  assign w_len_head  = r_len_mem[r_len_rd[LW-1:0]];
  assign w_data_head = r_data_mem[r_data_rd[AW-1:0]];
  assign w_xfer      = !w_len_empty && i_out_enq_rdy;

  assign o_out_enq_ena_c  = w_xfer;
  assign o_out_enq_v_c    = w_len_empty ? '0 : w_data_head;
  assign o_out_enq_size_c = w_len_empty ? 16'd0 : 16'(w_len_head);

  // Storage arrays carry no reset; reads are masked until a packet is complete
  always_ff @(posedge i_clk) begin
    if (w_in_acc) begin
      r_data_mem[r_data_wr[AW-1:0]] <= i_in_enq_v;
    end
    if (w_len_push) begin
      r_len_mem[r_len_wr[LW-1:0]] <= SW'(r_in_count) + SW'(1);
    end
  end

  // Pointer and input beat counter update
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_data_wr  <= '0;
      r_data_rd  <= '0;
      r_len_wr   <= '0;
      r_len_rd   <= '0;
      r_in_count <= '0;
    end else begin
      if (w_in_acc) begin
        r_data_wr  <= r_data_wr + PW'(1);
        r_in_count <= w_len_push ? '0 : r_in_count + AW'(1);
      end
      if (w_xfer) begin
        r_data_rd <= r_data_rd + PW'(1);
      end
      if (w_len_push) begin
        r_len_wr <= r_len_wr + LPW'(1);
      end
      if (w_len_pop) begin
        r_len_rd <= r_len_rd + LPW'(1);
      end
    end
  end

  // Output packet state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_out_remaining <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_out_remaining <= w_remaining_nxt;
    end
  end

  // Output next-state: count beats of the head packet, pop its length on the final beat
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_out_remaining;
    w_len_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (w_len_head == SW'(1)) begin
            w_len_pop = 1'b1;
          end else begin
            w_state_nxt     = S_BUSY;
            w_remaining_nxt = AW'(w_len_head - SW'(1));
          end
        end
      end
      S_BUSY: begin
        if (w_xfer) begin
          w_remaining_nxt = r_out_remaining - AW'(1);
          if (r_out_remaining == AW'(1)) begin
            w_len_pop   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_remaining_nxt = '0;
      end
    endcase
  end

`ifdef PIPE_LAST_TO_LENGTH_STATS_EN
  logic [31:0] r_pkt_count;
  logic [15:0] r_trunc_count;

  // Saturating statistics counters
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pkt_count   <= '0;
      r_trunc_count <= '0;
    end else begin
      if (w_len_pop && (r_pkt_count != '1)) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
      if (w_len_push && !i_in_enq_last && (r_trunc_count != '1)) begin
        r_trunc_count <= r_trunc_count + 16'd1;
      end
    end
  end

  assign o_pkt_count   = r_pkt_count;
  assign o_trunc_count = r_trunc_count;
`endif

endmodule
